// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: synchronous-read instruction memory with an IF-stage fetch handshake.
// Define IMEM_BOOT_IMAGE_EN to preload a small boot image during the INIT sweep.
module imem_fetch_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst,
  output logic [ADDR_W-1:0]        inst_addr,
  output logic                     fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);

  localparam int unsigned OFF   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned HI    = OFF + IDX_W;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nx;
  logic [IDX_W-1:0]  sweep_cnt;
  logic              sweep_last_c;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic [IDX_W-1:0]  fetch_idx_c;
  logic              misaligned_c;
  logic              out_of_range_c;
  logic              bad_c;
  logic              accept_c;

`ifdef IMEM_BOOT_IMAGE_EN
  // Boot image words; anything past the image is zero.
  function automatic logic [DATA_W-1:0] boot_word(input logic [IDX_W-1:0] k);
    logic [31:0] w;
    case (k)
      IDX_W'(0): w = 32'h0109_5020;
      IDX_W'(1): w = 32'h0AC0_A000;
      IDX_W'(2): w = 32'h0149_5822;
      IDX_W'(3): w = 32'h1168_FFFC;
      IDX_W'(4): w = 32'h0AC0_A000;
      default:   w = 32'h0000_0000;
    endcase
    return DATA_W'(w);
  endfunction
`endif

  // Fetch decode: word index plus alignment and range checks.
  assign fetch_idx_c    = IDX_W'(fetch_addr >> OFF);
  assign misaligned_c   = (fetch_addr & OFF_MASK) != '0;
  assign out_of_range_c = (fetch_addr >> HI) != '0;
  assign bad_c          = misaligned_c | out_of_range_c;
  assign accept_c       = ready & fetch_req & ~stall & ~flush;
  assign sweep_last_c   = (sweep_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and memory write-port steering.
  always_comb begin
    state_nx    = state;
    mem_we_c    = 1'b0;
    mem_waddr_c = prog_addr;
    mem_wdata_c = prog_data;
    case (state)
      S_INIT: begin
        mem_we_c    = ~reset;
        mem_waddr_c = sweep_cnt;
`ifdef IMEM_BOOT_IMAGE_EN
        mem_wdata_c = boot_word(sweep_cnt);
`else
        mem_wdata_c = '0;
`endif
        if (sweep_last_c) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        mem_we_c = prog_we & ~reset;
      end
      default: begin
        state_nx = S_INIT;
      end
    endcase
  end

  // Sweep counter walks every index once while in INIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      sweep_cnt <= '0;
    end else if (state == S_INIT) begin
      sweep_cnt <= sweep_cnt + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= (state_nx == S_RUN);
    end
  end

  // Storage array; no reset, contents are established by the INIT sweep.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Output register: flush beats stall, stall holds everything.
  // The read uses the pre-edge array, so a same-index write returns the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_addr  <= '0;
      fault      <= 1'b0;
    end else if (flush) begin
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else if (!stall) begin
      inst_valid <= accept_c;
      fault      <= accept_c & bad_c;
      if (accept_c) begin
        inst_addr <= fetch_addr;
        inst      <= bad_c ? '0 : mem[fetch_idx_c];
      end
    end
  end

endmodule
